// File: rtl/fwd_sel_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_sel_ctrl
//   Forwarding-select and load-use stall controller for the EX-stage
//   3-to-1 operand muxes. Keeps its own shadow copy of the ID/EX, EX/MEM
//   and MEM/WB destination/read information, so it needs nothing from the
//   datapath beyond the decoded fields of the instruction currently in ID.
//
//   Select codes: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           synchronous reset, active-high
//   id_rs1/rs2    source registers of the ID instruction
//   id_use_rs1/2  ID instruction really reads rs1/rs2
//   id_rd         destination register of the ID instruction
//   id_reg_write  ID instruction writes rd
//   id_mem_read   ID instruction is a load
//   flush         squash the ID instruction (branch/jump redirect)
//   fwd_a/fwd_b   operand A/B mux selects (combinational, shadow regs only)
//   stall         hold PC and IF/ID, bubble into ID/EX
//   stall_cnt     saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_sel_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } idex_t;

  // The load flag is not carried past EX: a load's data is forwarded from
  // MEM/WB like any other result, and the only load-specific decision
  // (the stall) is taken while the load sits in ID/EX.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
  } wr_t;

  idex_t            r_idex;
  wr_t              r_exmem;
  wr_t              r_memwb;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hazard;
  logic             w_stall;
  idex_t            w_idex_nxt;

  // -------------------------------------------------------------------------
  // Load-use hazard: the load in EX produces data too late for the ID
  // instruction's EX cycle. x0 never hazards.
  // -------------------------------------------------------------------------
  always_comb begin
    w_hazard = 1'b0;
    if (r_idex.mr && (r_idex.rd != '0)) begin
      w_hazard = ((r_idex.rd == id_rs1) && id_use_rs1) ||
                 ((r_idex.rd == id_rs2) && id_use_rs2);
    end
  end

  // A flushed ID instruction is dead, so it cannot hold the pipe.
  assign w_stall = w_hazard & ~flush;

  // -------------------------------------------------------------------------
  // ID/EX capture: flush and stall both insert a bubble; stalled ID inputs
  // are re-presented by upstream next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    w_idex_nxt = '0;
    if (!flush && !w_stall) begin
      w_idex_nxt.rs1  = id_rs1;
      w_idex_nxt.rs2  = id_rs2;
      w_idex_nxt.use1 = id_use_rs1;
      w_idex_nxt.use2 = id_use_rs2;
      w_idex_nxt.rd   = id_rd;
      w_idex_nxt.rw   = id_reg_write;
      w_idex_nxt.mr   = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      r_idex     <= w_idex_nxt;
      r_exmem.rd <= r_idex.rd;
      r_exmem.rw <= r_idex.rw;
      r_memwb    <= r_exmem;
    end
  end

  // -------------------------------------------------------------------------
  // Saturating stall counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_stall && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Per-operand forwarding select. Operand 0 is A (rs1), operand 1 is B (rs2).
  // EX/MEM is checked first so the youngest producer wins.
  // -------------------------------------------------------------------------
  logic [NUM_OPS-1:0][REG_AW-1:0] w_rs;
  logic [NUM_OPS-1:0]             w_use;
  logic [NUM_OPS-1:0][1:0]        w_sel;

  assign w_rs[0]  = r_idex.rs1;
  assign w_rs[1]  = r_idex.rs2;
  assign w_use[0] = r_idex.use1;
  assign w_use[1] = r_idex.use2;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_ex_hit = w_use[g] && r_exmem.rw && (r_exmem.rd != '0) &&
                      (r_exmem.rd == w_rs[g]);
    assign w_wb_hit = w_use[g] && r_memwb.rw && (r_memwb.rd != '0) &&
                      (r_memwb.rd == w_rs[g]);

    always_comb begin
      w_sel[g] = 2'b00;
      if (w_ex_hit)      w_sel[g] = 2'b01;
      else if (w_wb_hit) w_sel[g] = 2'b10;
    end
  end

  assign fwd_a     = w_sel[0];
  assign fwd_b     = w_sel[1];
  assign stall     = w_stall;
  assign stall_cnt = r_cnt;

endmodule
